packet_framer: RTL and testbench
================================

# packet_framer

Store-and-forward transmitter that builds the framed byte stream the stream parser consumes on its `packet_in` port. Upstream logic writes a payload, one byte at a time, over a valid/ready handshake and marks the final byte with `in_last`. The block buffers the complete payload, then emits it as one contiguous frame: SOF, length, payload, XOR checksum. It sits at the sending end of the link and drives one byte per clock with no output backpressure.

## Interface
- `DEPTH`, 16: maximum payload bytes; power of two, 2..128.
- `SOF`, 8'hA5: start-of-frame byte.
- `IDLE_BYTE`, 8'h00: value driven on `packet_out` when no frame is in flight.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  8  payload byte.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  qualifies the final payload byte of a packet.
- `in_ready`  out  1  block accepts a byte this cycle.
- `packet_out`  out  8  framed byte stream (registered).
- `out_valid`  out  1  `packet_out` holds a frame byte (registered).
- `busy`  out  1  frame transmission in progress.
- `overflow`  out  1  one-cycle pulse when a payload exceeds `DEPTH`.

## Operation
- The input handshake fires on a rising edge when `in_valid && in_ready`. The block ignores `in_last` and `in_data` unless `in_valid` is high.
- State `FILL` (reset state):
  - `in_ready`=1.
  - Each accepted byte is written to buffer[count]; count increments and the checksum accumulator is XORed with the byte.
  - An accepted byte with `in_last` moves the block to `SEND_SOF`.
  - An accepted byte arriving when count==`DEPTH` triggers overflow: the byte is discarded, `overflow` pulses, and count and the accumulator are cleared. If that byte carries `in_last`, the block stays in `FILL`; otherwise it goes to `DISCARD`.
- State `DISCARD`:
  - `in_ready`=1; all bytes are dropped.
  - The accepted `in_last` byte returns the block to `FILL`.
- Send states: `SEND_SOF` → `SEND_LEN` → `SEND_PAY` → `SEND_CHK` → `FILL`.
  - `in_ready`=0 and `busy`=1 in every send state.
  - `SEND_PAY` lasts N cycles, reading buffer[0..N-1] in order.
- Length byte = N, the number of payload bytes, 1..`DEPTH`.
- Checksum = N XOR payload[0] XOR … XOR payload[N-1], 8-bit.
- `in_ready` and `busy` are combinational decodes of state.
- `packet_out` and `out_valid` are registered from next-state logic.

## Timing
- Reset (asynchronous, while `rst`=1):
  - `packet_out`=`IDLE_BYTE`, `out_valid`=0, `busy`=0, `overflow`=0.
  - State=`FILL`, count=0, accumulator=0.
  - `in_ready` reads 1, but no byte is accepted while `rst` is high.
- Reset mid-frame aborts the frame immediately. The partial payload is discarded and no checksum byte is sent.
- The edge that accepts the `in_last` byte loads SOF, so SOF is visible with `out_valid`=1 in the following cycle (latency 1).
- The frame then runs on consecutive cycles: SOF, N, payload[0..N-1], checksum. That is N+3 cycles with `out_valid` continuously high and no gaps.
- The edge ending the checksum cycle clears `out_valid` and restores `packet_out`=`IDLE_BYTE`, `busy`=0 and `in_ready`=1. A new byte can be accepted on the next edge.
- Minimum spacing between frames is therefore one idle cycle.
- `overflow` is high for exactly the cycle after the offending edge.
- A payload of exactly `DEPTH` bytes ending with `in_last` is legal and sends normally.
- A zero-length packet is impossible: the framer never sends length 0.

## Test plan
- Send payload 10,20,F0 with `in_last` on F0 → `packet_out` = A5,03,10,20,F0,C3 on 6 consecutive `out_valid` cycles, then 00 with `out_valid`=0.
- Send a single byte 7E with `in_last` → frame A5,01,7E,7F. `in_ready` is 0 for the 4 frame cycles and returns to 1 in the cycle after the checksum.
- Send `DEPTH`=16 bytes 00..0F, last on 0F → length byte 10, checksum = 10 XOR (00^…^0F) = 10. No `overflow`.
- Send 18 bytes with last on the 18th → `overflow` pulses once after the 17th byte and no frame is emitted. A following packet AA(last) yields A5,01,AA,AB.
- Assert `rst` during payload byte 2 of a 3-byte frame → `out_valid` drops to 0 and `packet_out`=00 at once. After release, packet 55(last) yields A5,01,55,54.
- Hold `in_valid`=1 with back-to-back packets [01,02(last)] and [03(last)] → frames A5,02,01,02,01 and A5,01,03,02, separated by exactly one idle cycle.

Source files
------------

// File: rtl/packet_framer.sv
// Store-and-forward framer: buffers one payload, then emits SOF, length,
// payload and XOR checksum on consecutive cycles.
module packet_framer #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  SOF       = 8'hA5,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] packet_out,
  output logic       out_valid,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    FILL,
    DISCARD,
    SEND_SOF,
    SEND_LEN,
    SEND_PAY,
    SEND_CHK
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] rd_idx;
  logic [7:0]    acc;
  logic [7:0]    buf_mem [DEPTH];
  logic          accept;
  logic          full;

  assign in_ready = (state == FILL) || (state == DISCARD);
  assign busy     = ~in_ready;
  assign accept   = in_valid && in_ready;
  assign full     = (count == CW'(DEPTH));

  // Payload storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (state == FILL && accept && !full) begin
      buf_mem[count[AW-1:0]] <= in_data;
    end
  end

  // Each output register is loaded with the byte belonging to the state
  // being entered, so packet_out always matches the current send state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      count      <= '0;
      rd_idx     <= '0;
      acc        <= '0;
      packet_out <= IDLE_BYTE;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;
      unique case (state)
        FILL: begin
          if (accept) begin
            if (full) begin
              overflow <= 1'b1;
              count    <= '0;
              acc      <= '0;
              if (!in_last) state <= DISCARD;
            end else begin
              count <= count + CW'(1);
              acc   <= acc ^ in_data;
              if (in_last) begin
                state      <= SEND_SOF;
                packet_out <= SOF;
                out_valid  <= 1'b1;
              end
            end
          end
        end
        DISCARD: begin
          if (accept && in_last) state <= FILL;
        end
        SEND_SOF: begin
          state      <= SEND_LEN;
          packet_out <= 8'(count);
        end
        SEND_LEN: begin
          state      <= SEND_PAY;
          packet_out <= buf_mem[AW'(0)];
          rd_idx     <= CW'(1);
        end
        SEND_PAY: begin
          if (rd_idx == count) begin
            state      <= SEND_CHK;
            packet_out <= acc ^ 8'(count);
          end else begin
            packet_out <= buf_mem[rd_idx[AW-1:0]];
            rd_idx     <= rd_idx + CW'(1);
          end
        end
        SEND_CHK: begin
          state      <= FILL;
          packet_out <= IDLE_BYTE;
          out_valid  <= 1'b0;
          count      <= '0;
          acc        <= '0;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// Bench for packet_framer: directed and random packets checked against a
// frame-building reference model.
module tb_packet_framer;

  localparam int unsigned DEPTH     = 16;
  localparam logic [7:0]  SOF       = 8'hA5;
  localparam logic [7:0]  IDLE_BYTE = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] packet_out;
  logic       out_valid;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  packet_framer #(.DEPTH(DEPTH), .SOF(SOF), .IDLE_BYTE(IDLE_BYTE)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .packet_out(packet_out), .out_valid(out_valid),
    .busy(busy), .overflow(overflow)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  int exp_ovf = 0;
  logic [7:0] pay[$];
  logic [7:0] drv_d[$];
  logic       drv_l[$];
  logic [7:0] exp_q[$];
  int         exp_len[$];
  logic [7:0] obs[$];
  int         obs_cyc[$];

  // Output monitor: records every framed byte with its cycle number.
  always @(negedge clk) begin
    cyc++;
    if (out_valid) begin
      obs.push_back(packet_out);
      obs_cyc.push_back(cyc);
    end
    if (overflow) ovf_cnt++;
  end

  task automatic clear_model();
    obs.delete(); obs_cyc.delete(); exp_q.delete(); exp_len.delete();
    drv_d.delete(); drv_l.delete();
    exp_ovf = 0; ovf_cnt = 0;
  endtask

  // Reference: queue the packet for driving and append its expected frame.
  task automatic model_pkt();
    logic [7:0] chk;
    chk = 8'(pay.size());
    foreach (pay[i]) begin
      drv_d.push_back(pay[i]);
      drv_l.push_back(i == pay.size() - 1);
      chk = chk ^ pay[i];
    end
    if (pay.size() > int'(DEPTH)) begin
      exp_ovf++;
    end else begin
      exp_q.push_back(SOF);
      exp_q.push_back(8'(pay.size()));
      foreach (pay[i]) exp_q.push_back(pay[i]);
      exp_q.push_back(chk);
      exp_len.push_back(pay.size() + 3);
    end
  endtask

  task automatic drive(input int gap_pct);
    int t;
    while (drv_d.size() > 0) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = drv_d.pop_front(); in_last = drv_l.pop_front();
      t = 0;
      while (!in_ready && t < 200) begin @(negedge clk); t++; end
      if (!in_ready) begin
        total++; bad++;
        $display("FAIL drive_ready_timeout got=%b exp=1", in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (obs.size() < n && t < 2000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h33; in_last = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (packet_out !== IDLE_BYTE) begin bad++; $display("FAIL rst_packet_out got=%h exp=%h", packet_out, IDLE_BYTE); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk); rst = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    total++; if (obs.size() != 0) begin bad++; $display("FAIL rst_no_frame got=%0d exp=0", obs.size()); end
  endtask

  task automatic test_basic();
    clear_model();
    pay = '{8'h10, 8'h20, 8'hF0}; model_pkt();
    drive(0); wait_out(exp_q.size());
    total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin bad++; $display("FAIL basic_byte%0d got=%h exp=%h", i, (i < obs.size()) ? obs[i] : 8'hxx, exp_q[i]); end
    end
    total++; if (obs.size() != 6 || obs_cyc[5] - obs_cyc[0] != 5) begin bad++; $display("FAIL basic_contiguous got=%0d bytes exp=6 consecutive", obs.size()); end
    total++; if (out_valid !== 1'b0 || packet_out !== IDLE_BYTE) begin bad++; $display("FAIL basic_idle got=%b/%h exp=0/%h", out_valid, packet_out, IDLE_BYTE); end
  endtask

  task automatic test_single();
    clear_model();
    pay = '{8'h7E}; model_pkt();
    drive(0);
    total++; if (out_valid !== 1'b1 || packet_out !== SOF) begin bad++; $display("FAIL single_latency got=%b/%h exp=1/%h", out_valid, packet_out, SOF); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_ready_cyc%0d got=%b/%b exp=0/1", i, in_ready, busy); end
      @(negedge clk);
    end
    total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL single_release got=%b/%b/%b exp=1/0/0", in_ready, busy, out_valid); end
    wait_out(exp_q.size());
    total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL single_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin bad++; $display("FAIL single_byte%0d got=%h exp=%h", i, (i < obs.size()) ? obs[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_full_depth();
    clear_model();
    pay.delete();
    for (int i = 0; i < int'(DEPTH); i++) pay.push_back(8'(i));
    model_pkt();
    drive(0); wait_out(exp_q.size());
    total++; if (ovf_cnt != 0) begin bad++; $display("FAIL full_overflow got=%0d exp=0", ovf_cnt); end
    total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL full_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin bad++; $display("FAIL full_byte%0d got=%h exp=%h", i, (i < obs.size()) ? obs[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    clear_model();
    pay.delete();
    for (int i = 0; i < int'(DEPTH) + 2; i++) pay.push_back(8'($urandom));
    model_pkt();
    pay = '{8'hAA}; model_pkt();
    drive(0); wait_out(exp_q.size());
    total++; if (ovf_cnt != exp_ovf) begin bad++; $display("FAIL ovf_pulses got=%0d exp=%0d", ovf_cnt, exp_ovf); end
    total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, (i < obs.size()) ? obs[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    int k;
    int t;
    clear_model();
    pay = '{8'($urandom), 8'($urandom), 8'($urandom)}; model_pkt();
    drive(0);
    k = out_valid ? 1 : 0;
    t = 0;
    while (k < 4 && t < 20) begin
      @(negedge clk); t++;
      if (out_valid) k++;
    end
    total++; if (k != 4) begin bad++; $display("FAIL midrst_reach got=%0d exp=4", k); end
    #1 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || packet_out !== IDLE_BYTE) begin bad++; $display("FAIL midrst_abort got=%b/%h exp=0/%h", out_valid, packet_out, IDLE_BYTE); end
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL midrst_state got=%b/%b exp=0/1", busy, in_ready); end
    @(negedge clk); rst = 1'b0;
    clear_model();
    repeat (6) @(negedge clk);
    total++; if (obs.size() != 0) begin bad++; $display("FAIL midrst_no_tail got=%0d exp=0", obs.size()); end
    pay = '{8'h55}; model_pkt();
    drive(0); wait_out(exp_q.size());
    total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_byte%0d got=%h exp=%h", i, (i < obs.size()) ? obs[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_model();
    pay = '{8'h01, 8'h02}; model_pkt();
    pay = '{8'h03}; model_pkt();
    drive(0); wait_out(exp_q.size());
    total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, (i < obs.size()) ? obs[i] : 8'hxx, exp_q[i]); end
    end
    total++;
    if (obs.size() != 9 || obs_cyc[4] - obs_cyc[0] != 4 || obs_cyc[8] - obs_cyc[5] != 3 || obs_cyc[5] - obs_cyc[4] != 2) begin
      bad++; $display("FAIL b2b_spacing got=%0d bytes exp=9 with one idle gap", obs.size());
    end
  endtask

  task automatic test_random();
    int idx;
    int len;
    clear_model();
    for (int p = 0; p < 14; p++) begin
      if ($urandom_range(5) == 0) len = int'(DEPTH) + 1 + int'($urandom_range(3));
      else len = int'($urandom_range(int'(DEPTH), 1));
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      model_pkt();
    end
    drive(30); wait_out(exp_q.size());
    total++; if (ovf_cnt != exp_ovf) begin bad++; $display("FAIL rnd_overflow got=%0d exp=%0d", ovf_cnt, exp_ovf); end
    total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_byte%0d got=%h exp=%h", i, (i < obs.size()) ? obs[i] : 8'hxx, exp_q[i]); end
    end
    idx = 0;
    foreach (exp_len[f]) begin
      total++;
      if (idx + exp_len[f] > obs.size() || obs_cyc[idx + exp_len[f] - 1] - obs_cyc[idx] != exp_len[f] - 1) begin
        bad++; $display("FAIL rnd_frame%0d_contiguous got=%0d bytes exp=%0d", f, obs.size(), idx + exp_len[f]);
      end
      idx += exp_len[f];
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_full_depth();
    test_overflow();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
